// File: rtl/cpu_pkg.sv
// Shared decode constants, ALU operation enum and the ID/EX pipeline register layout.
package cpu_pkg;

    localparam int unsigned XLEN_MAX = 64;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
    } alu_op_t;

    // Operands sized for the widest datapath; narrower cores use the low XLEN bits.
    typedef struct packed {
        logic                valid;
        logic                illegal;
        logic [4:0]          rd;
        alu_op_t             op;
        logic [XLEN_MAX-1:0] a;
        logic [XLEN_MAX-1:0] b;
    } idex_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational integer ALU for the execute stage.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  alu_op_t           op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   result_o
);

    localparam int unsigned ShW = (XLEN == 64) ? 6 : 5;

    logic [ShW-1:0] shamt;
    assign shamt = b_i[ShW-1:0];

    always_comb begin
        result_o = '0;
        unique case (op_i)
            AluAdd:  result_o = a_i + b_i;
            AluSub:  result_o = a_i - b_i;
            AluSll:  result_o = a_i << shamt;
            AluSlt:  result_o = XLEN'($signed(a_i) < $signed(b_i));
            AluSltu: result_o = XLEN'(a_i < b_i);
            AluXor:  result_o = a_i ^ b_i;
            AluSrl:  result_o = a_i >> shamt;
            AluSra:  result_o = $unsigned($signed(a_i) >>> shamt);
            AluOr:   result_o = a_i | b_i;
            AluAnd:  result_o = a_i & b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu_pipe.sv
// Two-stage RV32I integer core: decode/read into ID/EX, then execute/writeback with bypass.
module cpu_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            hold,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned RIdx = $clog2(NREGS);

    logic [XLEN-1:0] rf_q [NREGS];
    idex_t           idex_q, idex_d;
    logic            wb_valid_q, illegal_q, zero_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic [XLEN-1:0] ex_res;

    function automatic logic idx_bad(input logic [4:0] idx);
        return (NREGS < 32) && (idx >= 5'(NREGS));
    endfunction

    cpu_alu #(.XLEN(XLEN)) u_alu (
        .op_i     (idex_q.op),
        .a_i      (idex_q.a[XLEN-1:0]),
        .b_i      (idex_q.b[XLEN-1:0]),
        .result_o (ex_res)
    );

    logic [6:0]      opcode, f7, sh_hi;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic            legal, is_reg, ex_fwd;
    alu_op_t         dec_op;
    logic [XLEN-1:0] opa, opb, imm;

    assign opcode = in[6:0];
    assign rd     = in[11:7];
    assign f3     = in[14:12];
    assign rs1    = in[19:15];
    assign rs2    = in[24:20];
    assign f7     = in[31:25];
    assign is_reg = (opcode == OP_REG);
    assign imm    = {{(XLEN-12){in[31]}}, in[31:20]};
    // RV64 immediate shifts borrow imm[5] as shamt[5], so only imm[11:6] is a funct field.
    assign sh_hi  = (XLEN == 64) ? {f7[6:1], 1'b0} : f7;
    assign ex_fwd = idex_q.valid && (idex_q.rd != 5'd0);

    always_comb begin
        legal  = 1'b0;
        dec_op = AluAdd;
        if (is_reg) begin
            legal = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == F3_ADD) || (f3 == F3_SR)));
            legal = legal && !idx_bad(rs2);
        end else if (opcode == OP_IMM) begin
            if (f3 == F3_SLL) begin
                legal = (sh_hi == 7'b0000000);
            end else if (f3 == F3_SR) begin
                legal = (sh_hi == 7'b0000000) || (sh_hi == 7'b0100000);
            end else begin
                legal = 1'b1;
            end
        end
        legal = legal && !idx_bad(rd) && !idx_bad(rs1);

        case (f3)
            F3_ADD:  dec_op = (is_reg && f7[5]) ? AluSub : AluAdd;
            F3_SLL:  dec_op = AluSll;
            F3_SLT:  dec_op = AluSlt;
            F3_SLTU: dec_op = AluSltu;
            F3_XOR:  dec_op = AluXor;
            F3_SR:   dec_op = f7[5] ? AluSra : AluSrl;
            F3_OR:   dec_op = AluOr;
            default: dec_op = AluAnd;
        endcase
    end

    always_comb begin
        if (rs1 == 5'd0) begin
            opa = '0;
        end else if (ex_fwd && (idex_q.rd == rs1)) begin
            opa = ex_res;
        end else begin
            opa = rf_q[rs1[RIdx-1:0]];
        end

        if (!is_reg) begin
            opb = imm;
        end else if (rs2 == 5'd0) begin
            opb = '0;
        end else if (ex_fwd && (idex_q.rd == rs2)) begin
            opb = ex_res;
        end else begin
            opb = rf_q[rs2[RIdx-1:0]];
        end
    end

    always_comb begin
        idex_d              = '0;
        idex_d.valid        = in_valid && legal;
        idex_d.illegal      = in_valid && !legal;
        idex_d.rd           = rd;
        idex_d.op           = dec_op;
        idex_d.a[XLEN-1:0]  = opa;
        idex_d.b[XLEN-1:0]  = opb;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q     <= '0;
            wb_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            zero_q     <= 1'b1;
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (hold) begin
            wb_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            idex_q     <= idex_d;
            wb_valid_q <= idex_q.valid;
            illegal_q  <= idex_q.illegal;
            if (idex_q.valid) begin
                wb_rd_q   <= idex_q.rd;
                wb_data_q <= ex_res;
                zero_q    <= (ex_res == '0);
                if (idex_q.rd != 5'd0) begin
                    rf_q[idex_q.rd[RIdx-1:0]] <= ex_res;
                end
            end
        end
    end

    logic unused_hi;
    assign unused_hi = ^{idex_q.a, idex_q.b};

    assign in_ready = !hold;
    assign wb_valid = wb_valid_q && !hold;
    assign illegal  = illegal_q && !hold;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_cpu_pipe.sv
// Directed bench driving three cpu_pipe configurations (32/32, 64/32, 32/16) in lockstep.
module tb_cpu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in;
    logic        in_valid;
    logic        hold;

    logic        rdy32, wv32, z32, il32;
    logic [4:0]  rd32;
    logic [31:0] d32;
    logic        rdy64, wv64, z64, il64;
    logic [4:0]  rd64;
    logic [63:0] d64;
    logic        rdye, wve, ze, ile;
    logic [4:0]  rde;
    logic [31:0] de;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_pipe #(.XLEN(32), .NREGS(32)) u_d32 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(rdy32), .hold(hold),
        .wb_valid(wv32), .wb_rd(rd32), .wb_data(d32), .zero(z32), .illegal(il32)
    );

    cpu_pipe #(.XLEN(64), .NREGS(32)) u_d64 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(rdy64), .hold(hold),
        .wb_valid(wv64), .wb_rd(rd64), .wb_data(d64), .zero(z64), .illegal(il64)
    );

    cpu_pipe #(.XLEN(32), .NREGS(16)) u_de (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(rdye), .hold(hold),
        .wb_valid(wve), .wb_rd(rde), .wb_data(de), .zero(ze), .illegal(ile)
    );

    function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] it(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] instr);
        in       = instr;
        in_valid = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; in = '0; in_valid = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wb_valid", 64'(wv32), 64'd0);
        check("rst_wb_rd",    64'(rd32), 64'd0);
        check("rst_wb_data",  64'(d32),  64'd0);
        check("rst_zero",     64'(z32),  64'd1);
        check("rst_illegal",  64'(il32), 64'd0);
        check("rst_in_ready", 64'(rdy32), 64'd1);
        rst = 1'b1;
        tick();

        // First two instructions, then a dependent ADD using the bypass on both operands.
        issue(rt(7'd0, 5'd2, 5'd1, 3'b000, 5'd3));
        check("add_latency", 64'(wv32), 64'd0);
        issue(it(12'd99, 5'd4, 3'b000, 5'd16));
        check("add_wv",   64'(wv32), 64'd1);
        check("add_rd",   64'(rd32), 64'd3);
        check("add_data", 64'(d32),  64'd0);
        check("add_zero", 64'(z32),  64'd1);
        issue(rt(7'd0, 5'd16, 5'd16, 3'b000, 5'd7));
        check("addi_rd",   64'(rd32), 64'd16);
        check("addi_data", 64'(d32),  64'd99);
        check("addi_zero", 64'(z32),  64'd0);
        in_valid = 1'b0;
        tick();
        check("byp_rd",   64'(rd32), 64'd7);
        check("byp_data", 64'(d32),  64'd198);
        check("byp64_data", d64, 64'd198);
        tick();
        check("bubble_wv",   64'(wv32), 64'd0);
        check("bubble_zero", 64'(z32),  64'd0);

        // Signed and width behaviour on the 32- and 64-bit cores.
        issue(it(12'hFFF, 5'd0, 3'b000, 5'd1));
        issue(it(12'h404, 5'd1, 3'b101, 5'd2));
        check("addi_m1_32", 64'(d32), 64'hFFFF_FFFF);
        check("addi_m1_64", d64, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(it(12'h01C, 5'd1, 3'b101, 5'd3));
        check("srai_32", 64'(d32), 64'hFFFF_FFFF);
        check("srai_64", d64, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(rt(7'd0, 5'd1, 5'd0, 3'b011, 5'd4));
        check("srli28_32", 64'(d32), 64'hF);
        check("srli28_64", d64, 64'hF_FFFF_FFFF);
        issue(rt(7'd0, 5'd1, 5'd0, 3'b010, 5'd5));
        check("sltu_32", 64'(d32), 64'd1);
        check("sltu_64", d64, 64'd1);
        issue(it(12'h03C, 5'd1, 3'b101, 5'd3));
        check("slt_32", 64'(d32), 64'd0);
        check("slt_64", d64, 64'd0);
        check("slt_zero", 64'(z32), 64'd1);
        in_valid = 1'b0;
        tick();
        check("srli60_64",    d64, 64'hF);
        check("srli60_rd64",  64'(rd64), 64'd3);
        check("srli60_il32",  64'(il32), 64'd1);
        check("srli60_wv32",  64'(wv32), 64'd0);
        tick();
        check("srli60_pulse", 64'(il32), 64'd0);

        // Hold with an ADD in ID/EX right after a retirement.
        issue(it(12'd7, 5'd0, 3'b000, 5'd9));
        issue(rt(7'd0, 5'd1, 5'd1, 3'b000, 5'd6));
        check("pre_hold_wv", 64'(wv32), 64'd1);
        hold = 1'b1;
        in   = it(12'd5, 5'd0, 3'b000, 5'd8);
        #1;
        check("hold_ready", 64'(rdy32), 64'd0);
        check("hold_mask",  64'(wv32),  64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_wv", 64'(wv32), 64'd0);
            check("hold_rd", 64'(rd32), 64'd9);
        end
        hold     = 1'b0;
        in_valid = 1'b0;
        tick();
        check("rel_wv",   64'(wv32), 64'd1);
        check("rel_rd",   64'(rd32), 64'd6);
        check("rel_data", 64'(d32),  64'hFFFF_FFFE);
        tick();
        check("rel_once", 64'(wv32), 64'd0);
        issue(rt(7'd0, 5'd9, 5'd8, 3'b000, 5'd10));
        in_valid = 1'b0;
        tick();
        check("x8_untouched", 64'(d32), 64'd7);
        check("e_add10_rd",   64'(rde), 64'd10);
        check("e_add10_data", 64'(de),  64'd7);

        // Register index beyond NREGS on the 16-register core.
        issue(rt(7'd0, 5'd2, 5'd1, 3'b000, 5'd20));
        in_valid = 1'b0;
        tick();
        check("e_x20_il",   64'(ile), 64'd1);
        check("e_x20_wv",   64'(wve), 64'd0);
        check("e_x20_rd",   64'(rde), 64'd10);
        check("e_x20_data", 64'(de),  64'd7);
        check("x20_32",     64'(d32), 64'hFFFF_FFFE);
        tick();
        check("e_x20_pulse", 64'(ile), 64'd0);

        // Unsupported opcode (branch).
        issue(32'h0020_8063);
        in_valid = 1'b0;
        tick();
        check("beq_il", 64'(il32), 64'd1);
        check("beq_wv", 64'(wv32), 64'd0);
        check("beq_rd", 64'(rd32), 64'd20);
        tick();
        check("beq_pulse", 64'(il32), 64'd0);

        // Reset with instructions in flight.
        issue(it(12'd5, 5'd0, 3'b000, 5'd1));
        in = it(12'd3, 5'd0, 3'b000, 5'd11);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_wv",   64'(wv32), 64'd0);
        check("mid_rst_rd",   64'(rd32), 64'd0);
        check("mid_rst_data", 64'(d32),  64'd0);
        check("mid_rst_zero", 64'(z32),  64'd1);
        check("mid_rst_il",   64'(il32), 64'd0);
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        check("post_rst_wv", 64'(wv32), 64'd0);
        tick();
        check("post_rst_wv2", 64'(wv32), 64'd0);
        issue(rt(7'd0, 5'd0, 5'd1, 3'b000, 5'd12));
        in_valid = 1'b0;
        tick();
        check("x1_reset_wv",   64'(wv32), 64'd1);
        check("x1_reset_rd",   64'(rd32), 64'd12);
        check("x1_reset_data", 64'(d32),  64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
